// File: rtl/pwm_peripheral.sv
// ---------------------------------------------------------------------------
// pwm_peripheral
//
// Sixteen-channel PWM output block driven from an SPI register file.
// A prescaler divides clk down to PWM counter steps; an 8-bit period counter
// sweeps 0..255 so one PWM period is 256*PRESCALE clk cycles.  All channels
// share one duty value, which is captured into a shadow register only at the
// period boundary so that a period is never disturbed by a mid-period write.
//
// Ports
//   clk              : system clock, rising edge
//   rst              : synchronous active-high reset
//   en_reg_out_7_0   : output enable, channels 7..0
//   en_reg_out_15_8  : output enable, channels 15..8
//   en_reg_pwm_7_0   : PWM mode select, channels 7..0 (0 = static high)
//   en_reg_pwm_15_8  : PWM mode select, channels 15..8
//   pwm_duty_cycle   : requested duty (0 = never high, 255 = always high)
//   out              : registered channel outputs, bit i = channel i
//   period_start     : registered one-cycle strobe on the first clk in which
//                      out reflects pcnt == 0 (not in the first period
//                      after reset)
// ---------------------------------------------------------------------------
module pwm_peripheral #(
   parameter int unsigned PRESCALE = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [15:0] pscnt_q, pscnt_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic [7:0]  duty_sh_q, duty_sh_d;
   logic [15:0] out_q, out_d;
   logic        wrap_q, wrap_d;
   logic        period_start_q, period_start_d;

   logic        tick;
   logic        pwm_raw;
   logic [15:0] en_out;
   logic [15:0] en_pwm;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // With PRESCALE = 1 the prescaler sits at 0 and tick is permanently high.
   assign tick = (pscnt_q == PS_LAST);

   always_comb begin
      pscnt_d        = tick ? 16'd0 : pscnt_q + 16'd1;
      pcnt_d         = tick ? pcnt_q + 8'd1 : pcnt_q;
      // Last step of the period: pcnt is about to wrap to 0.
      wrap_d         = tick && (pcnt_q == 8'hFF);
      duty_sh_d      = wrap_d ? pwm_duty_cycle : duty_sh_q;
      // out lags pcnt by one clk, so the strobe lags the wrap by one clk to
      // line up with the first output sample of the new period.
      period_start_d = wrap_q;
      // 255 is special-cased so "full duty" is genuinely always high rather
      // than high for 255 of 256 steps.
      pwm_raw        = (duty_sh_q == 8'hFF) || (pcnt_q < duty_sh_q);
   end

   // Per-channel output select: disabled -> 0, static mode -> 1, PWM -> raw.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_chan
         assign out_d[gi] = en_out[gi] & (~en_pwm[gi] | pwm_raw);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pscnt_q        <= 16'd0;
         pcnt_q         <= 8'd0;
         duty_sh_q      <= 8'd0;
         out_q          <= 16'h0000;
         wrap_q         <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         pscnt_q        <= pscnt_d;
         pcnt_q         <= pcnt_d;
         duty_sh_q      <= duty_sh_d;
         out_q          <= out_d;
         wrap_q         <= wrap_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule
